dma_burst_mem_responder: RTL and testbench



---
 rtl/dma_burst_mem_responder_if.sv | 42 ++++
 rtl/dma_burst_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_dma_burst_mem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_burst_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_mem_responder_if
// Description : Burst read/write request and beat channels between the DMA
//               engine (master) and its memory responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface dma_burst_mem_responder_if;
    logic [31:0] rd_req_addr;
    logic [4:0]  rd_req_len;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_rdata;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;

    logic [31:0] wr_req_addr;
    logic [4:0]  wr_req_len;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_last;
    logic        wr_err;

    modport master (
        output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        input  rd_req_ready, rd_rdata, rd_valid, rd_last,
        input  wr_req_ready, wr_ready, wr_err
    );

    modport slave (
        input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        output rd_req_ready, rd_rdata, rd_valid, rd_last,
        output wr_req_ready, wr_ready, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/dma_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_mem_responder
// Description : Word-addressed memory answering independent DMA read and
//               write bursts. Optional random back-pressure: DMA_MEM_STALL_EN.
// Revision    : 1.0  initial release
// ============================================================================
module dma_burst_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    dma_burst_mem_responder_if.slave bus
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_DATA = 1'b1
    } wr_state_t;

    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_ptr,   w_rd_ptr_nxt;
    logic [4:0]            r_rd_cnt,   w_rd_cnt_nxt;

    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr,   w_wr_ptr_nxt;
    logic [4:0]            r_wr_cnt,   w_wr_cnt_nxt;
    logic                  r_wr_err,   w_wr_err_nxt;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic                  w_stall;
    logic                  w_rd_req_ready;
    logic                  w_rd_valid;
    logic                  w_rd_last;
    logic [DATA_WIDTH-1:0] w_rd_rdata;
    logic                  w_wr_req_ready;
    logic                  w_wr_ready;
    logic                  w_wr_beat;

    // Byte-lane and high address bits are don't-care for a word array.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.rd_req_addr[31:ADDR_WIDTH+2], bus.rd_req_addr[1:0],
                                  bus.wr_req_addr[31:ADDR_WIDTH+2], bus.wr_req_addr[1:0]};

`ifdef DMA_MEM_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_rd_req_ready = 1'b0;
        w_rd_valid     = 1'b0;
        w_rd_last      = 1'b0;
        w_rd_rdata     = '0;
        case (r_rd_state)
            RD_IDLE: begin
                w_rd_req_ready = !w_stall;
                if (bus.rd_req_valid && w_rd_req_ready) begin
                    w_rd_state_nxt = RD_DATA;
                    w_rd_ptr_nxt   = bus.rd_req_addr[ADDR_WIDTH+1:2];
                    w_rd_cnt_nxt   = bus.rd_req_len;
                end
            end
            RD_DATA: begin
                // Stalls never drop rd_valid, so a presented beat stays put.
                w_rd_valid = 1'b1;
                w_rd_rdata = r_mem[r_rd_ptr];
                w_rd_last  = (r_rd_cnt == 5'd0);
                if (bus.rd_ready) begin
                    if (w_rd_last) begin
                        w_rd_state_nxt = RD_IDLE;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);
                        w_rd_cnt_nxt = r_rd_cnt - 5'd1;
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_wr_err_nxt   = r_wr_err;
        w_wr_req_ready = 1'b0;
        w_wr_ready     = 1'b0;
        w_wr_beat      = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_wr_req_ready = !w_stall;
                if (bus.wr_req_valid && w_wr_req_ready) begin
                    w_wr_state_nxt = WR_DATA;
                    w_wr_ptr_nxt   = bus.wr_req_addr[ADDR_WIDTH+1:2];
                    w_wr_cnt_nxt   = bus.wr_req_len;
                end
            end
            WR_DATA: begin
                w_wr_ready = !w_stall;
                w_wr_beat  = bus.wr_valid && w_wr_ready;
                if (w_wr_beat) begin
                    // Burst length comes from the request; wr_last is only audited.
                    if (bus.wr_last != (r_wr_cnt == 5'd0)) begin
                        w_wr_err_nxt = 1'b1;
                    end
                    if (r_wr_cnt == 5'd0) begin
                        w_wr_state_nxt = WR_IDLE;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt - 5'd1;
                    end
                    w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(1);
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_wr_ptr   <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wr_err   <= w_wr_err_nxt;
        end
    end

    // Array contents survive reset; a beat already accepted is always stored.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.rd_req_ready = w_rd_req_ready;
    assign bus.rd_valid     = w_rd_valid;
    assign bus.rd_last      = w_rd_last;
    assign bus.rd_rdata     = w_rd_rdata;
    assign bus.wr_req_ready = w_wr_req_ready;
    assign bus.wr_ready     = w_wr_ready;
    assign bus.wr_err       = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_burst_mem_responder
// Description : Directed self-checking bench for dma_burst_mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dma_burst_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_burst_mem_responder_if bus ();

    dma_burst_mem_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] wdata [32];
    logic [31:0] rbeat [32];
    logic        rlast [32];
    int          rd_nbeats, rd_lat, rd_end_cyc, rd_hold_viol, rd_reqrdy_viol;
    bit          rd_timeout;
    int          wr_viol;

    // Issue a read burst and collect beats; mode 0 = rd_ready always high,
    // mode 1 = rd_ready high on every third valid cycle (1,0,0,1,0,0,...).
    task automatic do_read(input logic [31:0] addr, input logic [4:0] len, input int mode);
        logic [31:0] pd;
        logic        pl;
        bit          held;
        bit          done;
        pd = '0; pl = 1'b0; held = 1'b0; done = 1'b0;
        @(negedge clk);
        bus.rd_req_addr  = addr;
        bus.rd_req_len   = len;
        bus.rd_req_valid = 1'b1;
        bus.rd_ready     = 1'b0;
        rd_nbeats = 0; rd_lat = -1; rd_end_cyc = -1;
        rd_hold_viol = 0; rd_reqrdy_viol = 0; rd_timeout = 1'b1;
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            bus.rd_req_valid = 1'b0;
            if (held && (bus.rd_valid !== 1'b1 || bus.rd_rdata !== pd || bus.rd_last !== pl))
                rd_hold_viol++;
            if (bus.rd_valid === 1'b1) begin
                if (rd_lat < 0) rd_lat = cyc;
                if (bus.rd_req_ready !== 1'b0) rd_reqrdy_viol++;
                bus.rd_ready = (mode == 0 || ((cyc - rd_lat) % 3) == 0) ? 1'b1 : 1'b0;
                if (bus.rd_ready) begin
                    if (rd_nbeats < 32) begin
                        rbeat[rd_nbeats] = bus.rd_rdata;
                        rlast[rd_nbeats] = bus.rd_last;
                    end
                    rd_nbeats++;
                    held = 1'b0;
                    if (bus.rd_last === 1'b1) begin
                        done = 1'b1; rd_end_cyc = cyc; rd_timeout = 1'b0;
                    end else if (rd_nbeats >= 40) begin
                        done = 1'b1;
                    end
                end else begin
                    held = 1'b1; pd = bus.rd_rdata; pl = bus.rd_last;
                end
            end else begin
                bus.rd_ready = 1'b0;
            end
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    // Issue a write burst of len+1 beats from wdata[], marking wr_last on last_idx.
    task automatic do_write(input logic [31:0] addr, input logic [4:0] len, input int last_idx);
        wr_viol = 0;
        @(negedge clk);
        if (bus.wr_req_ready !== 1'b1) wr_viol++;
        bus.wr_req_addr  = addr;
        bus.wr_req_len   = len;
        bus.wr_req_valid = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            bus.wr_req_valid = 1'b0;
            if (bus.wr_ready !== 1'b1 || bus.wr_req_ready !== 1'b0) wr_viol++;
            bus.wr_data  = wdata[i];
            bus.wr_last  = (i == last_idx);
            bus.wr_valid = 1'b1;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.rd_req_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_req_ready: got %b expected 1", bus.rd_req_ready); end
        checks++; if (bus.wr_req_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_req_ready: got %b expected 1", bus.wr_req_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", bus.rd_last); end
        checks++; if (bus.rd_rdata !== 32'h0) begin errors++; $display("FAIL reset_rd_rdata: got %h expected 0", bus.rd_rdata); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        for (int i = 0; i < 8; i++) wdata[i] = 32'h11 * (i + 1);
        do_write(32'h100, 5'd7, 7);
        checks++; if (wr_viol !== 0) begin errors++; $display("FAIL wr_handshake_timing: got %0d violations expected 0", wr_viol); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_after_burst: got %b expected 0", bus.wr_ready); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clean: got %b expected 0", bus.wr_err); end
        do_read(32'h100, 5'd7, 0);
        checks++; if (rd_timeout !== 1'b0) begin errors++; $display("FAIL rd_timeout: got %b expected 0", rd_timeout); end
        checks++; if (rd_lat !== 1) begin errors++; $display("FAIL rd_latency: got %0d expected 1", rd_lat); end
        checks++; if (rd_nbeats !== 8) begin errors++; $display("FAIL rd_beat_count: got %0d expected 8", rd_nbeats); end
        checks++; if (rd_end_cyc !== 8) begin errors++; $display("FAIL rd_burst_cycles: got %0d expected 8", rd_end_cyc); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rbeat[i] !== 32'h11 * (i + 1)) begin errors++; $display("FAIL rd_beat%0d: got %h expected %h", i, rbeat[i], 32'h11 * (i + 1)); end
            checks++; if (rlast[i] !== (i == 7)) begin errors++; $display("FAIL rd_last%0d: got %b expected %b", i, rlast[i], (i == 7)); end
        end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_req_ready !== 1'b1) begin errors++; $display("FAIL rd_idle_after_burst: got valid=%b req_ready=%b expected 0/1", bus.rd_valid, bus.rd_req_ready); end
    endtask

    task automatic test_ready_toggle;
        do_read(32'h100, 5'd3, 1);
        checks++; if (rd_nbeats !== 4) begin errors++; $display("FAIL toggle_beat_count: got %0d expected 4", rd_nbeats); end
        checks++; if (rd_end_cyc !== 10) begin errors++; $display("FAIL toggle_end_cycle: got %0d expected 10", rd_end_cyc); end
        checks++; if (rd_hold_viol !== 0) begin errors++; $display("FAIL toggle_hold_stable: got %0d violations expected 0", rd_hold_viol); end
        checks++; if (rd_reqrdy_viol !== 0) begin errors++; $display("FAIL toggle_req_ready_low: got %0d violations expected 0", rd_reqrdy_viol); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbeat[i] !== 32'h11 * (i + 1)) begin errors++; $display("FAIL toggle_beat%0d: got %h expected %h", i, rbeat[i], 32'h11 * (i + 1)); end
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + i;
        // Word 4094 with junk in the ignored high and byte-lane bits.
        do_write(32'hABC0_3FFB, 5'd3, 3);
        do_read(32'h0, 5'd1, 0);
        checks++; if (rbeat[0] !== 32'hA2) begin errors++; $display("FAIL wrap_word0: got %h expected 000000a2", rbeat[0]); end
        checks++; if (rbeat[1] !== 32'hA3) begin errors++; $display("FAIL wrap_word1: got %h expected 000000a3", rbeat[1]); end
        do_read(32'h3FF8, 5'd3, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbeat[i] !== 32'hA0 + i) begin errors++; $display("FAIL wrap_read_beat%0d: got %h expected %h", i, rbeat[i], 32'hA0 + i); end
        end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wrap_wr_err: got %b expected 0", bus.wr_err); end
    endtask

    task automatic test_overlap;
        wdata[0] = 32'hDEAD_BEEF;
        fork
            do_read(32'h100, 5'd3, 0);
            do_write(32'h100, 5'd0, 0);
        join
        checks++; if (rbeat[0] !== 32'h11) begin errors++; $display("FAIL overlap_old_value: got %h expected 00000011", rbeat[0]); end
        checks++; if (rbeat[1] !== 32'h22) begin errors++; $display("FAIL overlap_beat1: got %h expected 00000022", rbeat[1]); end
        do_read(32'h100, 5'd0, 0);
        checks++; if (rbeat[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL overlap_new_value: got %h expected deadbeef", rbeat[0]); end
    endtask

    task automatic test_wr_err;
        @(negedge clk);
        bus.wr_req_addr  = 32'h200;
        bus.wr_req_len   = 5'd3;
        bus.wr_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.wr_req_valid = 1'b0;
            if (i == 1) begin
                checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_early: got %b expected 0", bus.wr_err); end
            end
            if (i == 2) begin
                checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set: got %b expected 1", bus.wr_err); end
            end
            bus.wr_data  = 32'h7000_0000 + i;
            bus.wr_last  = (i == 1);
            bus.wr_valid = 1'b1;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        checks++; if (bus.wr_ready !== 1'b0 || bus.wr_req_ready !== 1'b1) begin errors++; $display("FAIL wr_err_burst_done: got ready=%b req_ready=%b expected 0/1", bus.wr_ready, bus.wr_req_ready); end
        do_read(32'h200, 5'd3, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbeat[i] !== 32'h7000_0000 + i) begin errors++; $display("FAIL wr_err_data%0d: got %h expected %h", i, rbeat[i], 32'h7000_0000 + i); end
        end
        checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_sticky: got %b expected 1", bus.wr_err); end
    endtask

    task automatic test_reset_midburst;
        for (int i = 0; i < 8; i++) wdata[i] = 32'h5000_0000 + i;
        do_write(32'h0, 5'd7, 7);
        @(negedge clk);
        bus.wr_req_addr  = 32'h0;
        bus.wr_req_len   = 5'd7;
        bus.wr_req_valid = 1'b1;
        bus.rd_req_addr  = 32'h100;
        bus.rd_req_len   = 5'd7;
        bus.rd_req_valid = 1'b1;
        bus.rd_ready     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.wr_req_valid = 1'b0;
            bus.rd_req_valid = 1'b0;
            bus.wr_data  = 32'h6000_0000 + i;
            bus.wr_last  = 1'b0;
            bus.wr_valid = 1'b1;
        end
        @(negedge clk);
        checks++; if (bus.rd_valid !== 1'b1 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL midburst_active: got rd_valid=%b wr_ready=%b expected 1/1", bus.rd_valid, bus.wr_ready); end
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_req_ready !== 1'b1 || bus.wr_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got rd=%b wr=%b expected 1/1", bus.rd_req_ready, bus.wr_req_ready); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid_last: got %b/%b expected 0/0", bus.rd_valid, bus.rd_last); end
        checks++; if (bus.rd_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rd_rdata: got %h expected 0", bus.rd_rdata); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL midrst_wr_ready: got %b expected 0", bus.wr_ready); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL midrst_wr_err: got %b expected 0", bus.wr_err); end
        rst = 1'b0;
        // Orphan beats after reset must not land in the array.
        bus.wr_data  = 32'hBAD0_BAD0;
        bus.wr_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        do_read(32'h0, 5'd7, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbeat[i] !== ((i < 3) ? 32'h6000_0000 + i : 32'h5000_0000 + i)) begin
                errors++;
                $display("FAIL midrst_word%0d: got %h expected %h", i, rbeat[i], (i < 3) ? 32'h6000_0000 + i : 32'h5000_0000 + i);
            end
        end
    endtask

    initial begin
        bus.rd_req_addr  = '0;
        bus.rd_req_len   = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_ready     = 1'b0;
        bus.wr_req_addr  = '0;
        bus.wr_req_len   = '0;
        bus.wr_req_valid = 1'b0;
        bus.wr_data      = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_last      = 1'b0;

        test_reset();
        test_write_read();
        test_ready_toggle();
        test_wrap();
        test_overlap();
        test_wr_err();
        test_reset_midburst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
